uart_controller: RTL and testbench

- Full-duplex 8N1 UART: a transmitter serialises a parallel byte and a receiver deserialises a serial line into a byte, both driven from one system clock.
- Sits between a byte-wide host interface and the board-level serial pins.
- An optional internal loopback ties the TX line to the RX path for self-test.

---
 rtl/uart_controller_pkg.sv | 37 +++
 rtl/uart_rx.sv | 138 +++++++++++++
 rtl/uart_tx.sv | 122 ++++++++++++
 rtl/uart_controller.sv | 55 +++++
 tb/tb_uart_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_controller_pkg.sv
// Shared frame constants, FSM state types and baud-rate helper functions
// for the 8N1 UART transmitter and receiver.
package uart_controller_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

   function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
      return clock_rate / baud_rate;
   endfunction

   // Rounded to the nearest integer divider, never below one clock per tick.
   function automatic int rx_tick_div(input int clock_rate, input int baud_rate,
                                      input int oversample);
      int denom;
      int div;
      denom = baud_rate * oversample;
      div   = (clock_rate + denom / 2) / denom;
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises the serial line, oversamples it with a divided
// tick and recovers bytes sampled at mid-bit.
module uart_rx
   import uart_controller_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int TICK_DIV   = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_serial_i,
   output logic                 rx_done_o,
   output logic [DATA_BITS-1:0] rx_byte_o
);

   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic                 meta_q, sync_q, prev_q;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 done_q, done_d;
   logic                 tick;
   logic                 div_clr;

   assign tick = (div_q == DIV_LAST);

   // Synchroniser flops reset to the idle-high line level so reset is not seen as a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q     <= 1'b1;
         sync_q     <= 1'b1;
         prev_q     <= 1'b1;
         state_q    <= RX_IDLE;
         div_q      <= '0;
         tick_cnt_q <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         meta_q     <= rx_serial_i;
         sync_q     <= meta_q;
         prev_q     <= sync_q;
         state_q    <= state_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_q     <= byte_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      done_d     = 1'b0;
      div_clr    = 1'b0;

      unique case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync_q) begin
               div_clr    = 1'b1;
               tick_cnt_d = '0;
               state_d    = RX_START;
            end
         end
         RX_START: begin
            if (tick) begin
               if (tick_cnt_q == HALF_LAST) begin
                  // Restarting the count here puts every later sample at mid-bit.
                  tick_cnt_d = '0;
                  bit_d      = '0;
                  state_d    = sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (tick_cnt_q == FULL_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = {sync_q, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_LAST) begin
                     state_d = RX_STOP;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (tick_cnt_q == FULL_LAST) begin
                  tick_cnt_d = '0;
                  if (sync_q) begin
                     byte_d  = shift_q;
                     done_d  = 1'b1;
                     state_d = RX_IDLE;
                  end else begin
                     state_d = RX_WAIT_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         RX_WAIT_IDLE: begin
            if (sync_q) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      div_d = (div_clr || tick) ? '0 : div_q + 1'b1;
   end

   assign rx_done_o = done_q;
   assign rx_byte_o = byte_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: latches a byte at frame start and shifts it out LSB first
// between a low start bit and a high stop bit.
module uart_tx
   import uart_controller_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_start_i,
   input  logic [DATA_BITS-1:0] tx_byte_i,
   output logic                 tx_active_o,
   output logic                 tx_serial_o,
   output logic                 tx_done_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= TX_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = 1'b0;

      unique case (state_q)
         TX_IDLE: begin
            serial_d = 1'b1;
            active_d = 1'b0;
            if (tx_start_i) begin
               shift_d  = tx_byte_i;
               cnt_d    = '0;
               bit_d    = '0;
               serial_d = 1'b0;
               active_d = 1'b1;
               state_d  = TX_START;
            end
         end
         TX_START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               serial_d = shift_q[0];
               state_d  = TX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  bit_d    = '0;
                  serial_d = 1'b1;
                  state_d  = TX_STOP;
               end else begin
                  bit_d    = bit_q + 1'b1;
                  shift_d  = shift_q >> 1;
                  serial_d = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bit_q == STOP_LAST) begin
                  done_d   = 1'b1;
                  active_d = 1'b0;
                  state_d  = TX_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign tx_active_o = active_q;
   assign tx_serial_o = serial_q;
   assign tx_done_o   = done_q;

endmodule

// File: rtl/uart_controller.sv
// Full-duplex 8N1 UART top: independent transmitter and receiver, with an
// optional internal loopback of the TX line into the receiver.
module uart_controller
   import uart_controller_pkg::*;
#(
   parameter int CLOCK_RATE    = 25000000,
   parameter int BAUD_RATE     = 115200,
   parameter int RX_OVERSAMPLE = 16,
   parameter int LOOPBACK      = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_Tx_Ready,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Data,
   output logic                 o_Tx_Done,
   input  logic                 i_Rx_Data,
   output logic                 o_Rx_Done,
   output logic [DATA_BITS-1:0] o_Rx_Byte
);

   localparam int TX_CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
   localparam int RX_TICK_DIV     = rx_tick_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);

   logic tx_serial;
   logic rx_serial;

   assign rx_serial = (LOOPBACK != 0) ? tx_serial : i_Rx_Data;
   assign o_Tx_Data = tx_serial;

   uart_tx #(
      .CLKS_PER_BIT (TX_CLKS_PER_BIT)
   ) u_tx (
      .clk         (clk),
      .rst_n       (reset_n),
      .tx_start_i  (i_Tx_Ready),
      .tx_byte_i   (i_Tx_Byte),
      .tx_active_o (o_Tx_Active),
      .tx_serial_o (tx_serial),
      .tx_done_o   (o_Tx_Done)
   );

   uart_rx #(
      .OVERSAMPLE (RX_OVERSAMPLE),
      .TICK_DIV   (RX_TICK_DIV)
   ) u_rx (
      .clk         (clk),
      .rst_n       (reset_n),
      .rx_serial_i (rx_serial),
      .rx_done_o   (o_Rx_Done),
      .rx_byte_o   (o_Rx_Byte)
   );

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller: one direct-RX instance and one
// loopback instance, with TX and RX monitors popping expected bytes.
module tb_uart_controller;

   localparam int CPB = 217;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;

   logic       tx_ready = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_active, tx_data, tx_done;
   logic       rx_line = 1'b1;
   logic       rx_done;
   logic [7:0] rx_byte;

   logic       lb_ready = 1'b0;
   logic [7:0] lb_byte = 8'h00;
   logic       lb_tx_active, lb_tx_data, lb_tx_done;
   logic       lb_rx_line = 1'b0;   // held low: the loopback instance must ignore it
   logic       lb_rx_done;
   logic [7:0] lb_rx_byte;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] lb_q[$];
   int rx_done_n = 0, rx_pushed = 0;
   int lb_done_n = 0, lb_pushed = 0;

   always #5 clk = ~clk;

   uart_controller #(
      .CLOCK_RATE(25000000), .BAUD_RATE(115200), .RX_OVERSAMPLE(16), .LOOPBACK(0)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .i_Tx_Ready(tx_ready), .i_Tx_Byte(tx_byte),
      .o_Tx_Active(tx_active), .o_Tx_Data(tx_data), .o_Tx_Done(tx_done),
      .i_Rx_Data(rx_line), .o_Rx_Done(rx_done), .o_Rx_Byte(rx_byte)
   );

   uart_controller #(
      .CLOCK_RATE(25000000), .BAUD_RATE(115200), .RX_OVERSAMPLE(16), .LOOPBACK(1)
   ) dut_lb (
      .clk(clk), .reset_n(reset_n),
      .i_Tx_Ready(lb_ready), .i_Tx_Byte(lb_byte),
      .o_Tx_Active(lb_tx_active), .o_Tx_Data(lb_tx_data), .o_Tx_Done(lb_tx_done),
      .i_Rx_Data(lb_rx_line), .o_Rx_Done(lb_rx_done), .o_Rx_Byte(lb_rx_byte)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic exp_tx_bit(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return b[slot-1];
   endfunction

   // ---------------- TX monitor (direct instance) ----------------
   logic [7:0] tx_exp;
   logic       tx_in_frame = 1'b0;
   int         tx_idx = 0;
   int         tx_done_seen = 0;
   int         tx_slot_err[10];

   always @(negedge clk) begin
      if (!reset_n) begin
         tx_in_frame = 1'b0;
      end else if (tx_in_frame) begin
         if (tx_active && tx_idx < 3000) begin
            if (tx_idx < 10 * CPB && tx_data !== exp_tx_bit(tx_exp, tx_idx / CPB))
               tx_slot_err[tx_idx / CPB]++;
            tx_done_seen += int'(tx_done);
            tx_idx++;
         end else begin
            tx_done_seen += int'(tx_done);
            check("tx_active_cycles", tx_idx, 10 * CPB);
            check("tx_done_pulses", tx_done_seen, 1);
            for (int s = 0; s < 10; s++)
               check($sformatf("tx_slot%0d_bad_cycles", s), tx_slot_err[s], 0);
            tx_in_frame = 1'b0;
         end
      end else if (tx_active) begin
         if (tx_q.size() == 0) begin
            check("tx_unexpected_frame", tx_q.size(), 1);
            tx_exp = 8'h00;
         end else begin
            tx_exp = tx_q.pop_front();
         end
         for (int s = 0; s < 10; s++) tx_slot_err[s] = 0;
         if (tx_data !== 1'b0) tx_slot_err[0]++;
         tx_done_seen = int'(tx_done);
         tx_idx       = 1;
         tx_in_frame  = 1'b1;
      end else if (tx_done) begin
         check("tx_spurious_done", tx_done, 1'b0);
      end
   end

   // ---------------- RX monitors ----------------
   always @(negedge clk) begin
      if (reset_n && rx_done) begin
         rx_done_n++;
         if (rx_q.size() == 0) check("rx_unexpected_done", rx_done, 1'b0);
         else check("rx_byte", rx_byte, rx_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset_n && lb_rx_done) begin
         lb_done_n++;
         if (lb_q.size() == 0) check("lb_unexpected_done", lb_rx_done, 1'b0);
         else check("lb_rx_byte", lb_rx_byte, lb_q.pop_front());
      end
   end

   // ---------------- Stimulus ----------------
   task automatic pulse_tx(input logic [7:0] b);
      tx_q.push_back(b);
      tx_byte  = b;
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      tx_byte  = ~b;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(CPB);
      end
      rx_line = stop_bit;
      tick(CPB);
      rx_line = 1'b1;
   endtask

   task automatic expect_rx(input logic [7:0] b);
      rx_q.push_back(b);
      rx_pushed++;
   endtask

   task automatic expect_lb(input logic [7:0] b);
      lb_q.push_back(b);
      lb_pushed++;
   endtask

   task automatic wait_lb_done(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick(1);
         if (lb_rx_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   logic [7:0] lb_bytes [8] = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88};

   initial begin
      int   idle_bad;
      logic ok;

      // Reset values
      tick(5);
      check("rst_tx_data", tx_data, 1'b1);
      check("rst_tx_active", tx_active, 1'b0);
      check("rst_tx_done", tx_done, 1'b0);
      check("rst_rx_done", rx_done, 1'b0);
      check("rst_rx_byte", rx_byte, 8'h00);
      check("rst_lb_tx_data", lb_tx_data, 1'b1);
      reset_n = 1'b1;

      // Idle for 1000 cycles: nothing may move
      idle_bad = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (tx_active || tx_done || !tx_data || rx_done ||
             lb_tx_active || lb_tx_done || !lb_tx_data || lb_rx_done)
            idle_bad++;
      end
      check("idle_activity_cycles", idle_bad, 0);
      tick(1);

      // TX 0x55 and RX 0xA5 simultaneously
      expect_rx(8'hA5);
      fork
         begin pulse_tx(8'h55); tick(2300); end
         begin send_rx(8'hA5, 1'b1); tick(100); end
      join

      // Framing error: byte discarded, output held
      send_rx(8'hF0, 1'b0);
      tick(500);
      check("rx_byte_hold_after_frame_err", rx_byte, 8'hA5);
      expect_rx(8'h3C);
      send_rx(8'h3C, 1'b1);
      tick(100);

      // 3-cycle glitch on idle line
      rx_line = 1'b0;
      tick(3);
      rx_line = 1'b1;
      tick(400);

      // Loopback stream with i_Tx_Ready held high
      lb_byte = lb_bytes[0];
      expect_lb(lb_bytes[0]);
      lb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_lb_done(ok);
         check($sformatf("lb_done_in_time_%0d", i), ok, 1'b1);
         if (i < 7) begin
            lb_byte = lb_bytes[i+1];
            expect_lb(lb_bytes[i+1]);
         end else begin
            lb_ready = 1'b0;
         end
      end
      tick(200);

      // Reset during bit 4 of 0xFF, then a clean 0x0B frame
      pulse_tx(8'hFF);
      tick(5 * CPB + 100);
      reset_n = 1'b0;
      #1;
      check("midrst_tx_data", tx_data, 1'b1);
      check("midrst_tx_active", tx_active, 1'b0);
      tick(3);
      reset_n = 1'b1;
      tick(3);
      pulse_tx(8'h0B);
      tick(2300);

      // End-of-run accounting
      check("rx_done_count", rx_done_n, rx_pushed);
      check("lb_done_count", lb_done_n, lb_pushed);
      check("rx_queue_left", rx_q.size(), 0);
      check("lb_queue_left", lb_q.size(), 0);
      check("tx_queue_left", tx_q.size(), 0);
      check("tx_frame_open", tx_in_frame, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
